// File: rtl/psg_pkg.sv
// Shared constants for the SN76489-compatible PSG register interface:
// register indices, reset codes and CPU byte field positions.
package psg_pkg;

  localparam logic [2:0] REG_TONE0 = 3'd0;
  localparam logic [2:0] REG_ATT0  = 3'd1;
  localparam logic [2:0] REG_TONE1 = 3'd2;
  localparam logic [2:0] REG_ATT1  = 3'd3;
  localparam logic [2:0] REG_TONE2 = 3'd4;
  localparam logic [2:0] REG_ATT2  = 3'd5;
  localparam logic [2:0] REG_NOISE = 3'd6;
  localparam logic [2:0] REG_ATT3  = 3'd7;

  localparam logic [3:0] ATTENUATION_SILENT = 4'hF;

  localparam int LATCH_FLAG_BIT = 7;
  localparam int IDX_MSB        = 6;
  localparam int IDX_LSB        = 4;
  localparam int LOW_MSB        = 3;
  localparam int HIGH_MSB       = 5;
  localparam int NOISE_MSB      = 2;

  // Registers pair up per channel: index[2:1] selects the channel.
  function automatic logic [1:0] reg_channel(logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/psg_write_wait_timer.sv
// READY wait-state emulation: after each accepted byte, ready drops
// for exactly CYCLES cycles. Used only when PSG_WRITE_WAIT_EN is defined.
module psg_write_wait_timer #(
  parameter int unsigned CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready
);

  localparam int unsigned CW = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d == '0);
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/psg_register_interface.sv
// CPU write decoder for the SN76489-compatible PSG (latch/data bytes).
// Define PSG_WRITE_WAIT_EN to enable READY wait-state emulation.
module psg_register_interface
  import psg_pkg::*;
#(
  parameter int unsigned CONTROL_BITS      = 4,
  parameter int unsigned TONE_BITS         = 10,
  parameter int unsigned WRITE_WAIT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    write,
  output logic                    ready,
  output logic [TONE_BITS-1:0]    tone_period_0,
  output logic [TONE_BITS-1:0]    tone_period_1,
  output logic [TONE_BITS-1:0]    tone_period_2,
  output logic [2:0]              noise_control,
  output logic                    noise_reset,
  output logic [CONTROL_BITS-1:0] attenuation_0,
  output logic [CONTROL_BITS-1:0] attenuation_1,
  output logic [CONTROL_BITS-1:0] attenuation_2,
  output logic [CONTROL_BITS-1:0] attenuation_3
);

  logic [2:0][TONE_BITS-1:0]    tone_q, tone_d;
  logic [3:0][CONTROL_BITS-1:0] att_q, att_d;
  logic [2:0]                   noise_q, noise_d;
  logic                         nrst_q, nrst_d;
  logic [2:0]                   idx_q, idx_d;

  logic       accept;
  logic       is_latch;
  logic [2:0] tgt;
  logic [1:0] ch;

  assign accept   = write && ready;
  assign is_latch = data_in[LATCH_FLAG_BIT];
  // A latch byte addresses its own index in the same cycle it latches it.
  assign tgt      = is_latch ? data_in[IDX_MSB:IDX_LSB] : idx_q;
  assign ch       = reg_channel(tgt);

  always_comb begin
    idx_d   = idx_q;
    tone_d  = tone_q;
    att_d   = att_q;
    noise_d = noise_q;
    nrst_d  = 1'b0;
    if (accept) begin
      if (is_latch) begin
        idx_d = data_in[IDX_MSB:IDX_LSB];
      end
      unique case (tgt)
        REG_TONE0, REG_TONE1, REG_TONE2: begin
          if (is_latch) begin
            tone_d[ch][LOW_MSB:0] = data_in[LOW_MSB:0];
          end else begin
            tone_d[ch][TONE_BITS-1:LOW_MSB+1] = data_in[HIGH_MSB:0];
          end
        end
        REG_ATT0, REG_ATT1, REG_ATT2, REG_ATT3: begin
          att_d[ch] = CONTROL_BITS'(data_in[LOW_MSB:0]);
        end
        REG_NOISE: begin
          noise_d = data_in[NOISE_MSB:0];
          nrst_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_q  <= '0;
      att_q   <= {4{CONTROL_BITS'(ATTENUATION_SILENT)}};
      noise_q <= '0;
      nrst_q  <= 1'b0;
      idx_q   <= REG_TONE0;
    end else begin
      tone_q  <= tone_d;
      att_q   <= att_d;
      noise_q <= noise_d;
      nrst_q  <= nrst_d;
      idx_q   <= idx_d;
    end
  end

`ifdef PSG_WRITE_WAIT_EN
  psg_write_wait_timer #(
    .CYCLES(WRITE_WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .start(accept),
    .ready(ready)
  );
`else
  logic unused_wait;
  assign unused_wait = |WRITE_WAIT_CYCLES;
  assign ready       = 1'b1;
`endif

  assign tone_period_0 = tone_q[0];
  assign tone_period_1 = tone_q[1];
  assign tone_period_2 = tone_q[2];
  assign attenuation_0 = att_q[0];
  assign attenuation_1 = att_q[1];
  assign attenuation_2 = att_q[2];
  assign attenuation_3 = att_q[3];
  assign noise_control = noise_q;
  assign noise_reset   = nrst_q;

endmodule

// File: tb/tb_psg_register_interface.sv
// Scoreboard bench for psg_register_interface: directed bytes with
// hand-computed expected register values.
module tb_psg_register_interface;

  typedef enum logic [3:0] {
    K_T0, K_T1, K_T2, K_A0, K_A1, K_A2, K_A3, K_NZ
  } kind_e;

  typedef struct {
    kind_e      k;
    logic [9:0] v;
    logic       nr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       write = 1'b0;
  logic       ready;
  logic [9:0] tone_period_0, tone_period_1, tone_period_2;
  logic [2:0] noise_control;
  logic       noise_reset;
  logic [3:0] attenuation_0, attenuation_1, attenuation_2, attenuation_3;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  psg_register_interface #(
    .CONTROL_BITS(4),
    .TONE_BITS(10),
    .WRITE_WAIT_CYCLES(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .write        (write),
    .ready        (ready),
    .tone_period_0(tone_period_0),
    .tone_period_1(tone_period_1),
    .tone_period_2(tone_period_2),
    .noise_control(noise_control),
    .noise_reset  (noise_reset),
    .attenuation_0(attenuation_0),
    .attenuation_1(attenuation_1),
    .attenuation_2(attenuation_2),
    .attenuation_3(attenuation_3)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] field(kind_e k);
    case (k)
      K_T0:    return tone_period_0;
      K_T1:    return tone_period_1;
      K_T2:    return tone_period_2;
      K_A0:    return {6'd0, attenuation_0};
      K_A1:    return {6'd0, attenuation_1};
      K_A2:    return {6'd0, attenuation_2};
      K_A3:    return {6'd0, attenuation_3};
      default: return {7'd0, noise_control};
    endcase
  endfunction

  // Monitor: every accepting edge pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (write && ready && !reset) begin
        #1;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: got accept, expected none");
        end else begin
          e = sb.pop_front();
          chk(e.k.name(), field(e.k), e.v);
          chk("noise_reset", {9'd0, noise_reset}, {9'd0, e.nr});
        end
      end
    end
  end

  // Called at a negedge; drives one byte for one cycle.
  task automatic wr(logic [7:0] d, kind_e k, logic [9:0] v, logic nr);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", {9'd0, ready}, 10'd1);
    sb.push_back('{k: k, v: v, nr: nr});
    data_in = d;
    write   = 1'b1;
    @(negedge clk);
    write   = 1'b0;
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_t0"}, tone_period_0, 10'h000);
    chk({tag, "_t1"}, tone_period_1, 10'h000);
    chk({tag, "_t2"}, tone_period_2, 10'h000);
    chk({tag, "_a0"}, {6'd0, attenuation_0}, 10'h00F);
    chk({tag, "_a1"}, {6'd0, attenuation_1}, 10'h00F);
    chk({tag, "_a2"}, {6'd0, attenuation_2}, 10'h00F);
    chk({tag, "_a3"}, {6'd0, attenuation_3}, 10'h00F);
    chk({tag, "_nz"}, {7'd0, noise_control}, 10'h000);
    chk({tag, "_nr"}, {9'd0, noise_reset}, 10'h000);
    chk({tag, "_rdy"}, {9'd0, ready}, 10'h001);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state("rst_mid");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("rst_init");
    reset = 1'b0;
    @(negedge clk);

    wr(8'h8E, K_T0, 10'h00E, 1'b0);
    wr(8'h0F, K_T0, 10'h0FE, 1'b0);
    wr(8'h8A, K_T0, 10'h0FA, 1'b0);
    wr(8'h9A, K_A0, 10'h00A, 1'b0);
    chk("t0_kept", tone_period_0, 10'h0FA);
    wr(8'h03, K_A0, 10'h003, 1'b0);
    wr(8'hB7, K_A1, 10'h007, 1'b0);
    wr(8'hA1, K_T1, 10'h001, 1'b0);
    wr(8'h7F, K_T1, 10'h3F1, 1'b0);
    wr(8'hCC, K_T2, 10'h00C, 1'b0);
    wr(8'h12, K_T2, 10'h12C, 1'b0);
    wr(8'hE5, K_NZ, 10'h005, 1'b1);
    wr(8'h03, K_NZ, 10'h003, 1'b1);
    wr(8'h03, K_NZ, 10'h003, 1'b1);
    wr(8'h03, K_NZ, 10'h003, 1'b1);
    wr(8'hE3, K_NZ, 10'h003, 1'b1);
    wr(8'hFF, K_A3, 10'h00F, 1'b0);
    wr(8'hD2, K_A2, 10'h002, 1'b0);
    @(negedge clk);
    chk("nr_idle", {9'd0, noise_reset}, 10'h000);
    chk("a1_kept", {6'd0, attenuation_1}, 10'h007);

    async_reset();
    wr(8'h45, K_T0, 10'h050, 1'b0);
    wr(8'h8E, K_T0, 10'h05E, 1'b0);

`ifdef PSG_WRITE_WAIT_EN
    begin
      int n = 0;
      wr(8'h90, K_A0, 10'h000, 1'b0);
      chk("wait_low", {9'd0, ready}, 10'h000);
      data_in = 8'h9F;
      write   = 1'b1;
      while (!ready && n < 100) begin
        n++;
        if (n == 4) write = 1'b0;
        @(negedge clk);
      end
      write = 1'b0;
      chk("wait_len", n[9:0], 10'd32);
      chk("wait_ignored", {6'd0, attenuation_0}, 10'h000);
      wr(8'h9F, K_A0, 10'h00F, 1'b0);
      repeat (3) @(negedge clk);
      chk("wait_busy", {9'd0, ready}, 10'h000);
      async_reset();
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", 10'(sb.size()), 10'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psg_register_interface.md
Name: psg_register_interface

Overview:
- Bus-side write decoder for the SN76489-compatible PSG.
- Accepts CPU bytes in latch/data format and maintains the eight chip registers: three 10-bit tone periods, 3-bit noise control and four 4-bit attenuation codes.
- Produces the attenuation control codes consumed by the per-channel attenuation stages, plus the tone/noise settings for the generators.
- Optional READY wait-state emulation.

Parameters:
- CONTROL_BITS, 4, width of each attenuation code output; must be 4.
- TONE_BITS, 10, width of each tone period output; must be 10.
- WRITE_WAIT_CYCLES, 32, number of cycles ready stays low after an accepted byte (used only with PSG_WRITE_WAIT_EN).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  CPU write byte.
- write  in  1  byte valid strobe.
- ready  out  1  block can accept a byte.
- tone_period_0/1/2  out  TONE_BITS each  tone channel periods.
- noise_control  out  3  noise register: bit2 = white/periodic, bits1:0 = rate.
- noise_reset  out  1  one-cycle pulse on every noise register write.
- attenuation_0/1/2/3  out  CONTROL_BITS each  channel attenuation codes; channel 3 is noise.

Behaviour:
- Reset (async, dominant over everything):
  - tone_period_* = 0, noise_control = 0, noise_reset = 0.
  - attenuation_* = 4'hF (silent).
  - latched register index = 3'd0.
  - ready = 1; wait counter = 0.
- Accept rule:
  - A byte is accepted on a rising clk edge where write && ready.
  - write while ready=0 is ignored: no register change, no latch change.
  - All register outputs update at that same edge, i.e. visible one cycle after write is sampled. No pipelining beyond this single register stage.
- Register index: 0 = tone0, 1 = att0, 2 = tone1, 3 = att1, 4 = tone2, 5 = att2, 6 = noise, 7 = att3.
- Latch byte (data_in[7] = 1):
  - latched index := data_in[6:4].
  - Tone target: bits 3:0 of the period := data_in[3:0]; bits 9:4 unchanged.
  - Attenuation target: code := data_in[3:0].
  - Noise target: noise_control := data_in[2:0]; noise_reset pulses.
- Data byte (data_in[7] = 0): targets the current latched index, which is unchanged.
  - Tone: bits 9:4 := data_in[5:0]; bits 3:0 unchanged.
  - Attenuation: code := data_in[3:0].
  - Noise: noise_control := data_in[2:0]; noise_reset pulses.
  - data_in[6] is ignored.
- Data byte directly after reset targets tone0.
- noise_reset:
  - High exactly the cycle after the accepting edge.
  - Back-to-back noise writes produce back-to-back pulses.
- Writing a register with its current value still counts as a write; noise_reset still pulses.
- Without PSG_WRITE_WAIT_EN: ready is constant 1, so one byte can be accepted every cycle.

Optional Feature:
- Macro: PSG_WRITE_WAIT_EN.
- When defined:
  - On accept, ready goes low from the next cycle for exactly WRITE_WAIT_CYCLES cycles, then returns high. A down-counter runs WRITE_WAIT_CYCLES down to 0.
  - Writes during that window are ignored.
  - Reset mid-wait forces ready = 1 and clears the counter.
  - If WRITE_WAIT_CYCLES = 0, behaviour is identical to the undefined case.
- When undefined: no counter is instantiated and ready is tied to 1.

Decomposition:
- Package psg_pkg holds:
  - register index constants: REG_TONE0, REG_ATT0, REG_TONE1, REG_ATT1, REG_TONE2, REG_ATT2, REG_NOISE, REG_ATT3.
  - ATTENUATION_SILENT = 4'hF.
  - LATCH_FLAG_BIT = 7.
  - Byte field positions.
- One sub-module, psg_write_wait_timer, holds the ready/down-counter logic.
  - Instantiated only under PSG_WRITE_WAIT_EN.
  - Ports: clk, reset, start, ready.

Test Plan:
- Assert reset mid-run after arbitrary writes → all attenuation_* = 4'hF, tone_period_* = 0, noise_control = 0, ready = 1, without waiting for a clk edge.
- Write 0x8E then 0x0F → tone_period_0 = 10'h0FE; then 0x8A → tone_period_0 = 10'h0FA, upper bits kept.
- Write 0x9A → attenuation_0 = 4'hA, tone_period_0 unchanged; then 0x03 → attenuation_0 = 4'h3. Write 0xB7 → attenuation_1 = 4'h7.
- Write 0xE5 → noise_control = 3'b101 with a 1-cycle noise_reset; then 0x03 → noise_control = 3'b011 with a second pulse; write held 2 cycles on noise → 2 consecutive pulses.
- Write 0xFF then 0xD2 → attenuation_3 = 4'hF, attenuation_2 = 4'h2; data byte 0x45 right after reset → tone_period_0[9:4] = 6'h05.
- With PSG_WRITE_WAIT_EN and WRITE_WAIT_CYCLES = 32: write 0x90 → ready low for exactly 32 cycles; a 0x9F issued during the window is ignored (attenuation_0 stays 4'h0); 0x9F after ready rises is applied.
